// File: rtl/fetch_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller_if
// Description : Memory, redirect/halt control and decode-side handshake
//               signals of the instruction-fetch sequencer.
//               The master modport is the fetch controller.
//               The slave modport is the surrounding pipeline and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_controller_if;
    logic [63:0] imem_adr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        output imem_adr, out_valid, out_instr, out_pc, fault, fetch_count,
        input  imem_instr, redirect_valid, redirect_pc, halt_req, out_ready
    );

    modport slave (
        input  imem_adr, out_valid, out_instr, out_pc, fault, fetch_count,
        output imem_instr, redirect_valid, redirect_pc, halt_req, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : Instruction-fetch sequencer. Owns the PC and drives the
//               combinational instruction memory address. Registers one
//               (pc, instruction) pair per cycle behind a valid/ready stage.
//               Handles branch redirects, halt requests and sticky address
//               faults.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned MEM_BYTES = 64
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    fetch_controller_if.master bus
);

    localparam logic [1:0]  c_st_start  = 2'd0;
    localparam logic [1:0]  c_st_run    = 2'd1;
    localparam logic [1:0]  c_st_halted = 2'd2;
    localparam logic [1:0]  c_st_fault  = 2'd3;
    localparam logic [64:0] c_mem_bytes = 65'(MEM_BYTES);

    logic [1:0]  r_state, w_state;
    logic [63:0] r_pc, w_pc;
    logic        r_valid, w_valid;
    logic [31:0] r_instr, w_instr;
    logic [63:0] r_opc, w_opc;
    logic        r_fault, w_fault;
    logic [31:0] r_count;
    logic        w_fire;
    logic        w_load;

    // The add is done one bit wider so that a PC near the top of the address
    // space cannot wrap around and look like it is in range.
    function automatic logic f_legal(input logic [63:0] a);
        return (a[1:0] == 2'b00) && (({1'b0, a} + 65'd3) < c_mem_bytes);
    endfunction

    assign w_fire = r_valid && bus.out_ready;
    assign w_load = !r_valid || bus.out_ready;

    // Next-state, next-PC and output-register update.
    always_comb begin
        w_state = r_state;
        w_pc    = r_pc;
        w_valid = r_valid && !w_fire;
        w_instr = r_instr;
        w_opc   = r_opc;
        w_fault = r_fault;

        case (r_state)
            c_st_start: begin
                w_state = bus.halt_req ? c_st_halted : c_st_run;
            end
            c_st_run: begin
                // Halt is evaluated before load, so the fetch on a rising
                // halt_req edge is suppressed.
                if (bus.halt_req) begin
                    w_state = c_st_halted;
                end else if (!bus.redirect_valid && w_load) begin
                    if (f_legal(r_pc)) begin
                        w_instr = bus.imem_instr;
                        w_opc   = r_pc;
                        w_valid = 1'b1;
                        w_pc    = r_pc + 64'd4;
                    end else begin
                        w_valid = 1'b0;
                        w_fault = 1'b1;
                        w_state = c_st_fault;
                    end
                end
            end
            c_st_halted: begin
                if (!bus.halt_req) begin
                    w_state = c_st_run;
                end
            end
            default: begin
                if (bus.redirect_valid && f_legal(bus.redirect_pc)) begin
                    w_fault = 1'b0;
                    w_state = bus.halt_req ? c_st_halted : c_st_run;
                end
            end
        endcase

        // A redirect always wins: the new target replaces the PC and any
        // presented instruction is flushed.
        if (bus.redirect_valid) begin
            w_pc    = bus.redirect_pc;
            w_valid = 1'b0;
        end
    end

    // State, PC, output register and transfer counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_st_start;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_instr <= 32'h0;
            r_opc   <= 64'h0;
            r_fault <= 1'b0;
            r_count <= 32'h0;
        end else begin
            r_state <= w_state;
            r_pc    <= w_pc;
            r_valid <= w_valid;
            r_instr <= w_instr;
            r_opc   <= w_opc;
            r_fault <= w_fault;
            r_count <= r_count + {31'h0, w_fire};
        end
    end

    assign bus.imem_adr    = r_pc;
    assign bus.out_valid   = r_valid;
    assign bus.out_instr   = r_instr;
    assign bus.out_pc      = r_opc;
    assign bus.fault       = r_fault;
    assign bus.fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_controller
// Description : Self-checking bench for fetch_controller. Directed scenarios
//               followed by a randomized run, every cycle compared against
//               a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

    localparam int unsigned c_mem_bytes = 16;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    logic [7:0] mem [0:63];
    logic [5:0] w_ai;

    fetch_controller_if bus ();

    fetch_controller #(
        .RESET_PC  (64'h0),
        .MEM_BYTES (c_mem_bytes)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Little-endian combinational instruction memory.
    assign w_ai = bus.imem_adr[5:0];
    assign bus.imem_instr = (bus.imem_adr < 64'd61) ?
        {mem[w_ai + 6'd3], mem[w_ai + 6'd2], mem[w_ai + 6'd1], mem[w_ai]} : 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phase 0=start, 1=running, 2=halted, 3=faulted.
    int          m_ph;
    logic [63:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_opc;
    logic        m_fault;
    logic [31:0] m_count;

    function automatic logic [31:0] rd(input logic [63:0] a);
        int i;
        i = int'(a[5:0]);
        if (a >= 64'd61) return 32'h0;
        return {mem[i + 3], mem[i + 2], mem[i + 1], mem[i]};
    endfunction

    function automatic logic legal(input logic [63:0] a);
        return (a % 4 == 0) && (a <= 64'(c_mem_bytes - 4));
    endfunction

    task automatic model_step();
        int   ph0;
        logic draining;
        logic loading;
        if (!reset_n) begin
            m_ph = 0; m_pc = 64'h0; m_valid = 1'b0; m_instr = 32'h0;
            m_opc = 64'h0; m_fault = 1'b0; m_count = 32'h0;
            return;
        end
        ph0      = m_ph;
        draining = m_valid && bus.out_ready;
        loading  = (ph0 == 1) && !bus.halt_req && !bus.redirect_valid &&
                   (!m_valid || bus.out_ready);
        if (draining) begin
            m_count = m_count + 1;
            m_valid = 1'b0;
        end
        if (loading) begin
            if (legal(m_pc)) begin
                m_instr = rd(m_pc);
                m_opc   = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 4;
            end else begin
                m_fault = 1'b1;
                m_ph    = 3;
            end
        end
        if (bus.redirect_valid) begin
            m_valid = 1'b0;
            m_pc    = bus.redirect_pc;
            if (ph0 == 3 && legal(bus.redirect_pc)) begin
                m_fault = 1'b0;
                m_ph    = bus.halt_req ? 2 : 1;
            end
        end
        if (ph0 == 0)                       m_ph = bus.halt_req ? 2 : 1;
        else if (ph0 == 1 && bus.halt_req)  m_ph = 2;
        else if (ph0 == 2 && !bus.halt_req) m_ph = 1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("valid", {63'h0, bus.out_valid}, {63'h0, m_valid});
        check("out_pc", bus.out_pc, m_opc);
        check("out_instr", {32'h0, bus.out_instr}, {32'h0, m_instr});
        check("fault", {63'h0, bus.fault}, {63'h0, m_fault});
        check("count", {32'h0, bus.fetch_count}, {32'h0, m_count});
        check("imem_adr", bus.imem_adr, m_pc);
    endtask

    initial begin
        logic [63:0] pick;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hB3; mem[1] = 8'h00; mem[2] = 8'h31; mem[3] = 8'h00;
        mem[4] = 8'h33; mem[5] = 8'hF2; mem[6] = 8'h62; mem[7] = 8'h00;

        reset_n = 1'b0;
        bus.out_ready = 1'b1;
        bus.halt_req = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 64'h0;

        // Reset values, then straight-line fetch to the end of memory.
        tick(); tick();
        check("rst_valid", {63'h0, bus.out_valid}, 64'h0);
        check("rst_count", {32'h0, bus.fetch_count}, 64'h0);
        check("rst_adr", bus.imem_adr, 64'h0);
        reset_n = 1'b1;
        tick();
        check("start_valid", {63'h0, bus.out_valid}, 64'h0);
        tick();
        check("first_pc", bus.out_pc, 64'h0);
        check("first_instr", {32'h0, bus.out_instr}, 64'h003100B3);
        tick();
        check("second_pc", bus.out_pc, 64'h4);
        check("second_instr", {32'h0, bus.out_instr}, 64'h0062F233);
        tick();
        check("two_fired", {32'h0, bus.fetch_count}, 64'd2);
        tick(); tick();
        check("oor_fault", {63'h0, bus.fault}, 64'h1);
        check("oor_valid", {63'h0, bus.out_valid}, 64'h0);
        check("oor_adr", bus.imem_adr, 64'd16);
        tick();
        check("oor_frozen", bus.imem_adr, 64'd16);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0;
        tick();
        check("recover_fault", {63'h0, bus.fault}, 64'h0);
        bus.redirect_valid = 1'b0;
        tick();
        check("recover_valid", {63'h0, bus.out_valid}, 64'h1);
        check("recover_pc", bus.out_pc, 64'h0);

        // Backpressure, then a redirect that flushes the stalled pc=0 word.
        reset_n = 1'b0; tick();
        reset_n = 1'b1; tick(); tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_pc", bus.out_pc, 64'h0);
            check("bp_adr", bus.imem_adr, 64'h4);
            check("bp_count", {32'h0, bus.fetch_count}, 64'h0);
        end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h4;
        tick();
        check("redir_flush", {63'h0, bus.out_valid}, 64'h0);
        bus.redirect_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        check("redir_pc", bus.out_pc, 64'h4);
        check("redir_instr", {32'h0, bus.out_instr}, 64'h0062F233);
        check("redir_count", {32'h0, bus.fetch_count}, 64'h0);

        // Misaligned redirect faults on the following fetch attempt.
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h2;
        tick();
        check("mis_nofault", {63'h0, bus.fault}, 64'h0);
        bus.redirect_valid = 1'b0;
        tick();
        check("mis_fault", {63'h0, bus.fault}, 64'h1);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0;
        tick();
        bus.redirect_valid = 1'b0; bus.out_ready = 1'b0;
        tick();

        // Halt keeps the pending word presented until it drains.
        bus.halt_req = 1'b1;
        tick();
        check("halt_hold", {63'h0, bus.out_valid}, 64'h1);
        check("halt_adr", bus.imem_adr, 64'h4);
        bus.out_ready = 1'b1;
        tick();
        check("halt_drain", {63'h0, bus.out_valid}, 64'h0);
        tick();
        check("halt_idle", {63'h0, bus.out_valid}, 64'h0);
        bus.halt_req = 1'b0;
        tick(); tick();
        check("resume_pc", bus.out_pc, 64'h4);
        bus.out_ready = 1'b0;
        tick();

        // Reset mid-stream discards the pending output.
        reset_n = 1'b0;
        tick();
        check("mid_rst_valid", {63'h0, bus.out_valid}, 64'h0);
        check("mid_rst_adr", bus.imem_adr, 64'h0);
        check("mid_rst_count", {32'h0, bus.fetch_count}, 64'h0);
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset_n = ($urandom_range(63) != 0);
            bus.out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(5) == 0) bus.halt_req = ~bus.halt_req;
            bus.redirect_valid = ($urandom_range(7) == 0);
            case ($urandom_range(6))
                0: pick = 64'h0;
                1: pick = 64'h4;
                2: pick = 64'h8;
                3: pick = 64'hC;
                4: pick = 64'h10;
                5: pick = 64'h2;
                default: pick = {32'hFFFF_FFFF, 30'($urandom), 2'b00};
            endcase
            bus.redirect_pc = pick;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer sitting between the pipeline's byte-addressed, combinational-read instruction memory and the decode stage. Owns the program counter and drives the memory address. Latches one 32-bit instruction per cycle into a valid/ready output register, and handles branch redirects, halt requests and address faults. Decode sees a clean, flushable stream of (pc, instruction) pairs.

## Interface
- RESET_PC, 64'h0, PC loaded on reset; must be 4-byte aligned
- MEM_BYTES, 64, instruction memory size in bytes; fetch at pc is legal only if pc+3 < MEM_BYTES
- clk  input  1  clock; all state changes on rising edge
- reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- imem_adr  output  64  byte address to instruction memory, combinationally equal to pc
- imem_instr  input  32  instruction returned combinationally by memory for imem_adr, little-endian
- redirect_valid  input  1  load redirect_pc and flush the output register (branch/jump taken)
- redirect_pc  input  64  redirect target byte address
- halt_req  input  1  level; while high no new fetches are issued
- out_valid  output  1  out_instr/out_pc hold a fetched instruction
- out_ready  input  1  decode accepts; transfer ("fire") when out_valid && out_ready
- out_instr  output  32  fetched instruction
- out_pc  output  64  address of out_instr
- fault  output  1  sticky; fetch attempted at misaligned or out-of-range pc
- fetch_count  output  32  number of fired transfers, wraps at 2^32

## Operation
- Reset values:
  - pc=RESET_PC, state=START
  - out_valid=0, out_instr=0, out_pc=0
  - fault=0, fetch_count=0
- States:
  - START: one cycle after reset; goes to HALTED if halt_req, else RUN.
  - RUN: fetches. Goes to HALTED when halt_req=1. Goes to FAULT on an illegal fetch.
  - HALTED: no fetches. Goes to RUN when halt_req=0; goes through START only after reset.
  - FAULT: no fetches, fault=1. Leaves only via a legal redirect (to RUN, or to HALTED if halt_req=1) or reset.
- Load condition in RUN: load = !out_valid || out_ready, i.e. the register is empty or draining this cycle.
- Legal fetch: pc[1:0]==0 and pc+3 < MEM_BYTES.
- RUN with load and a legal pc:
  - out_instr<=imem_instr, out_pc<=pc, out_valid<=1.
  - pc<=pc+4, 64-bit wrapping add.
- RUN with load and an illegal pc:
  - out_valid<=0, fault<=1, state<=FAULT, pc unchanged.
- RUN without load: registers hold, pc holds (stall).
- Fire without a new load (HALTED, FAULT, START, or redirect cycle): out_valid<=0.
- fetch_count increments on every fire, including the fire in a redirect cycle.
- Redirect has priority over everything except reset, in any state:
  - pc<=redirect_pc, out_valid<=0; no fetch that cycle.
  - In FAULT: legality of redirect_pc is checked that cycle. If legal, fault<=0 and state leaves FAULT. If illegal, remain in FAULT.
  - Outside FAULT, an illegal redirect_pc faults on the next fetch attempt.
- halt_req does not flush: a valid output stays presented until it fires.
- Reset mid-operation discards any pending output; all outputs return to reset values the next cycle.

## Timing
- Fetch latency: pc presented at cycle t → out_valid/out_instr at t+1.
- Throughput: one instruction per cycle while out_ready=1 and RUN.
- First valid after reset release at edge t0:
  - START at t0.
  - RUN fetch at t0+1, out_valid=1 from t0+2.
- Redirect at edge t:
  - out_valid=0 after t.
  - Fetch at redirect_pc occurs at edge t+1; valid after t+1.
- Backpressure: out_instr/out_pc stable while out_valid && !out_ready; imem_adr stable as well.
- halt_req rising at edge t: the fetch at edge t is suppressed (state is evaluated before load). halt_req falling: fetch resumes at the next edge.
- fault asserted the cycle after the illegal fetch attempt edge.

## Test plan
- Memory bytes B3 00 31 00 33 F2 62 00, reset_n low 2 cycles, out_ready=1:
  - out_pc=0 / out_instr=32'h003100B3, then out_pc=4 / out_instr=32'h0062F233, one cycle apart.
  - fetch_count=2 after both fire.
- Backpressure: out_ready=0 for 3 cycles after the first valid → out_pc=0 held 3 cycles, imem_adr=4 held, no fetch_count change; release → pc=4 next.
- Redirect to 4 while out_pc=0 is valid and out_ready=0 → out_valid=0 next cycle, then out_pc=4 / out_instr=32'h0062F233; pc=0 instruction never fires.
- MEM_BYTES=8, run past pc=4 → fetch at pc=8 sets fault=1, out_valid=0, imem_adr=8 frozen; redirect to 0 → fault=0, out_pc=0 valid two edges later.
- Misaligned redirect to 2 → fault=1 on the next edge; halt_req=1 during RUN → no new fetch, pending output fires, then out_valid=0 until halt_req=0.
- Assert reset_n=0 mid-stream with out_valid=1 → next cycle out_valid=0, pc=RESET_PC, fetch_count=0, fault=0.
